uart_loader: RTL

UART_LOADER -- requirements
Module: uart_loader

---
 rtl/uart_loader.sv | 323 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_loader.sv
// uart_loader
//   Receives a boot image over a UART and writes it into instruction memory,
//   holding the core in reset until a complete frame with a good checksum
//   has been loaded.
//
//   Frame: 0xA5, LEN_LO, LEN_HI (N words), 4*N data bytes (little-endian per
//   word), checksum byte = XOR of all data bytes.
//
//   Optional feature macro: LOADER_ECHO_EN
//     defined   - uart_tx echoes each good byte, then 'K' on DONE / 'E' on ERR
//     undefined - uart_tx tied high
//
// Ports
//   CLK         system clock, rising edge
//   reset       asynchronous, active-low reset
//   uart_rx     serial in, 8N1, LSB first, idle high
//   uart_tx     serial out, 8N1
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   word address of the write
//   imem_wdata  assembled instruction word
//   core_rst_n  low holds the core in reset; high only in DONE
//   busy        high while a frame is being loaded
//   err         high in ERR
//
// Loader FSM states
//   state | meaning
//   IDLE  | waiting for 0xA5 header after reset
//   LEN0  | expecting word-count low byte
//   LEN1  | expecting word-count high byte
//   DATA  | assembling and writing instruction words
//   CSUM  | expecting checksum byte
//   DONE  | image loaded, core released; 0xA5 restarts
//   ERR   | framing/length/checksum error; 0xA5 restarts
module uart_loader #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);
  localparam logic [7:0] HDR = 8'hA5;

  // ---------------------------------------------------------------- RX
  logic rx_meta, rx_s, rx_s_d;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]       rx_bit, rx_bit_nxt;
  logic [7:0]       rx_shift, rx_shift_nxt;
  logic             rx_tc, rx_valid, rx_ferr;
  logic [7:0]       rx_byte;

  assign rx_tc   = (rx_cnt == '0);
  assign rx_byte = rx_shift;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  // rx_valid / rx_ferr are combinational on the stop-sample cycle so the
  // loader registers react on the very next cycle.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_valid     = 1'b0;
    rx_ferr      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_s_d && !rx_s) begin
          rx_state_nxt = RX_START;
          rx_cnt_nxt   = HALF_RELOAD;
        end
      end
      RX_START: begin
        if (!rx_tc) begin
          rx_cnt_nxt = rx_cnt - CNT_W'(1);
        end else if (!rx_s) begin
          rx_state_nxt = RX_DATA;
          rx_cnt_nxt   = BIT_RELOAD;
          rx_bit_nxt   = '0;
        end else begin
          rx_state_nxt = RX_IDLE;   // glitch, not a start bit
        end
      end
      RX_DATA: begin
        if (!rx_tc) begin
          rx_cnt_nxt = rx_cnt - CNT_W'(1);
        end else begin
          rx_shift_nxt = {rx_s, rx_shift[7:1]};
          rx_cnt_nxt   = BIT_RELOAD;
          rx_bit_nxt   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (!rx_tc) begin
          rx_cnt_nxt = rx_cnt - CNT_W'(1);
        end else begin
          rx_valid     = rx_s;
          rx_ferr      = !rx_s;
          rx_state_nxt = RX_IDLE;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- loader
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
  state_t             state, state_nxt;
  logic [7:0]         len_lo, len_lo_nxt;
  logic [15:0]        words_left, words_left_nxt;
  logic [1:0]         byte_sel, byte_sel_nxt;
  logic [23:0]        word_buf, word_buf_nxt;
  logic [7:0]         csum, csum_nxt;
  logic               imem_we_nxt;
  logic [ADDR_W-1:0]  imem_addr_nxt;
  logic [31:0]        imem_wdata_nxt;
  logic [15:0]        len_word;

  assign len_word = {rx_byte, len_lo};

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      len_lo     <= '0;
      words_left <= '0;
      byte_sel   <= '0;
      word_buf   <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state      <= state_nxt;
      len_lo     <= len_lo_nxt;
      words_left <= words_left_nxt;
      byte_sel   <= byte_sel_nxt;
      word_buf   <= word_buf_nxt;
      csum       <= csum_nxt;
      imem_we    <= imem_we_nxt;
      imem_addr  <= imem_addr_nxt;
      imem_wdata <= imem_wdata_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    len_lo_nxt     = len_lo;
    words_left_nxt = words_left;
    byte_sel_nxt   = byte_sel;
    word_buf_nxt   = word_buf;
    csum_nxt       = csum;
    imem_we_nxt    = 1'b0;
    imem_addr_nxt  = imem_addr;
    imem_wdata_nxt = imem_wdata;

    // Address advances while the strobe is visible, only if more words
    // follow; after the last word the FSM is already in CSUM, so the
    // address never wraps.
    if (imem_we && state == DATA) imem_addr_nxt = imem_addr + ADDR_W'(1);

    if (rx_ferr) begin
      state_nxt = ERR;
    end else if (rx_valid) begin
      case (state)
        IDLE, DONE, ERR: begin
          if (rx_byte == HDR) begin
            state_nxt     = LEN0;
            imem_addr_nxt = '0;
            byte_sel_nxt  = '0;
            csum_nxt      = '0;
          end
        end
        LEN0: begin
          len_lo_nxt = rx_byte;
          state_nxt  = LEN1;
        end
        LEN1: begin
          if ({1'b0, len_word} > MAX_WORDS) begin
            state_nxt = ERR;
          end else if (len_word == '0) begin
            state_nxt = CSUM;
          end else begin
            state_nxt      = DATA;
            words_left_nxt = len_word;
          end
        end
        DATA: begin
          csum_nxt     = csum ^ rx_byte;
          byte_sel_nxt = byte_sel + 2'd1;
          if (byte_sel == 2'd3) begin
            imem_we_nxt    = 1'b1;
            imem_wdata_nxt = {rx_byte, word_buf};
            words_left_nxt = words_left - 16'd1;
            if (words_left == 16'd1) state_nxt = CSUM;
          end else begin
            word_buf_nxt = {rx_byte, word_buf[23:8]};
          end
        end
        CSUM: state_nxt = (rx_byte == csum) ? DONE : ERR;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign core_rst_n = (state == DONE);
  assign busy       = (state inside {LEN0, LEN1, DATA, CSUM});
  assign err        = (state == ERR);

  // ---------------------------------------------------------------- TX echo
`ifdef LOADER_ECHO_EN
  state_t     state_d;
  logic [7:0] fifo_mem [2];
  logic       fifo_wp, fifo_rp;
  logic [1:0] fifo_cnt;
  logic       enter_done, enter_err, push, do_push, pop;
  logic [7:0] push_data;
  logic       tx_busy;
  logic [CNT_W-1:0] tx_cnt;
  logic [3:0] tx_bit;
  logic [8:0] tx_shift;

  // Status characters are pushed one cycle after the state change, which
  // is one cycle after the echo of the byte that caused it.
  assign enter_done = (state == DONE) && (state_d != DONE);
  assign enter_err  = (state == ERR)  && (state_d != ERR);
  assign push       = rx_valid || enter_done || enter_err;
  assign push_data  = rx_valid ? rx_byte : (enter_done ? 8'h4B : 8'h45);
  assign pop        = !tx_busy && (fifo_cnt != 2'd0);
  assign do_push    = push && ((fifo_cnt != 2'd2) || pop);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_d     <= IDLE;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wp     <= 1'b0;
      fifo_rp     <= 1'b0;
      fifo_cnt    <= '0;
    end else begin
      state_d <= state;
      if (do_push) begin
        fifo_mem[fifo_wp] <= push_data;
        fifo_wp           <= !fifo_wp;
      end
      if (pop) fifo_rp <= !fifo_rp;
      fifo_cnt <= fifo_cnt + {1'b0, do_push} - {1'b0, pop};
    end
  end

  // tx_bit counts the bit currently on the line: 0 start, 1..8 data, 9 stop.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
      uart_tx  <= 1'b1;
    end else if (!tx_busy) begin
      if (pop) begin
        tx_busy  <= 1'b1;
        uart_tx  <= 1'b0;
        tx_shift <= {1'b1, fifo_mem[fifo_rp]};
        tx_cnt   <= BIT_RELOAD;
        tx_bit   <= '0;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - CNT_W'(1);
    end else if (tx_bit == 4'd9) begin
      tx_busy <= 1'b0;
    end else begin
      uart_tx  <= tx_shift[0];
      tx_shift <= {1'b1, tx_shift[8:1]};
      tx_cnt   <= BIT_RELOAD;
      tx_bit   <= tx_bit + 4'd1;
    end
  end
`else
  assign uart_tx = 1'b1;
`endif

endmodule
